des_key_sched: RTL
==================

Name: des_key_sched

Overview:
- Iterative DES key schedule: takes one 64-bit key and streams the 16 round subkeys (48 bits each) to the round datapath.
- The stream feeds the XOR stage that follows the E expansion.
- Runs in either direction: encrypt order K1→K16 (left rotations), or decrypt order K16→K1 (right rotations).
- One subkey per cycle under valid/ready back-pressure.

Parameters:
- none (widths fixed by FIPS 46-3)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- key  input  64  DES key incl. parity bits; vector index n holds FIPS bit n+1
- decrypt  input  1  0 = encrypt order, 1 = decrypt order; sampled with key
- key_valid  input  1  key/decrypt valid
- key_ready  output  1  block can accept a key (IDLE)
- subkey  output  48  current subkey; index n holds PC-2 output bit n+1
- subkey_rnd  output  4  DES round number minus 1 of current subkey
- subkey_last  output  1  current subkey is the 16th of the stream
- subkey_valid  output  1  subkey/subkey_rnd/subkey_last valid
- subkey_ready  input  1  consumer accepts subkey
- busy  output  1  schedule in progress (RUN)
- parity_err  output  1  odd-parity violation on loaded key (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, key_ready=1, subkey_valid=0, busy=0, subkey_last=0, subkey_rnd=0, subkey=0, parity_err=0. C/D registers cleared.
- States: IDLE, RUN.
- IDLE:
  - key_ready=1.
  - On key_valid & key_ready: apply PC-1 to key, giving C0 and D0 (28 bits each); latch decrypt.
  - Encrypt: load C/D registers with C0/D0 rotated left by 1.
  - Decrypt: load C0/D0 unrotated (CD16 = CD0, total shift 28).
  - Set count=0; next state RUN.
- RUN:
  - key_ready=0, busy=1, subkey_valid=1.
  - subkey = PC-2(C,D), combinational from the C/D registers.
  - subkey_rnd = count (encrypt) or 15-count (decrypt).
  - subkey_last = (count==15).
- Advance on subkey_valid & subkey_ready: count++, and C/D rotate for the next round.
  - Encrypt: left by 1 when the next round is 2, 9 or 16; left by 2 otherwise.
  - Decrypt: right by 1 when leaving count 0, 7 or 14; right by 2 otherwise.
  - Handshake at count==15: return to IDLE; subkey_valid=0 next cycle.
- Back-pressure: while subkey_ready=0, subkey, subkey_rnd and subkey_last are held stable. No round is skipped or repeated. Exactly 16 handshakes per key.
- Latency: first subkey_valid one cycle after key acceptance. Sustained rate is 1 subkey/cycle.
- Between keys: at least one IDLE cycle after the last handshake. key_valid asserted during RUN is ignored (not accepted, not lost by the source).
- Reset mid-operation: rst has priority over every transfer. Next cycle is IDLE with reset values; any partial stream is dropped.
- Parity bits (FIPS 8, 16, …, 64) are discarded by PC-1.
- subkey_rnd wrap: never exceeds 15; count does not wrap.

Optional Feature:
- Macro: DES_KEY_PARITY_CHK_EN
- Defined:
  - On key acceptance, each key byte is checked for odd parity. parity_err registers 1 if any byte fails.
  - parity_err is held until the next key acceptance or rst.
  - The schedule still runs normally.
- Undefined: parity_err is tied 0 and no checker logic is built.

Test Plan:
- Reset: after rst, key_ready=1, subkey_valid=0, busy=0, parity_err=0.
- Encrypt, key 0x133457799BBCDFF1 (FIPS bit 1 = leftmost, subkeys written the same way):
  - first subkey 0x1B02EFFC7072 with rnd=0;
  - 16th subkey 0xCB3D8B0E17F5 with rnd=15 and last=1;
  - subkey_ready held 1 gives 16 consecutive valid cycles.
- Decrypt, same key: first subkey 0xCB3D8B0E17F5 with rnd=15; 16th subkey 0x1B02EFFC7072 with rnd=0 and last=1. The full sequence equals the reversed encrypt sequence.
- Back-pressure: subkey_ready random at 30% → exactly 16 handshakes; outputs stable while stalled; the sequence matches the unstalled run.
- Back-to-back and reset:
  - key_valid held with a second key: accepted 1 cycle after the last handshake; no key is accepted during RUN.
  - rst pulsed at rnd=5: the following cycle shows subkey_valid=0 and key_ready=1.
- DES_KEY_PARITY_CHK_EN:
  - key 0x133457799BBCDFF1 → parity_err=0;
  - key 0x133457799BBCDFF0 → parity_err=1, and the subkeys are still produced (identical to the first key, since only a parity bit differs).

Source files
------------

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: one 64-bit key in, 16 round subkeys out, in encrypt or decrypt order.
// Optional build macro DES_KEY_PARITY_CHK_EN adds an odd-parity check of the loaded key bytes.
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_rnd,
    output logic        subkey_last,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        parity_err
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Table entries are FIPS bit numbers, first entry = output bit 1.
    localparam logic [447:0] PC1_TBL = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39,
        8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38,
        8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
        8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    localparam logic [383:0] PC2_TBL = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
        8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
        8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
        8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
        8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  idx;
        r = 56'd0;
        for (int i = 0; i < 56; i++) begin
            idx  = 6'(PC1_TBL[8*(55-i) +: 8] - 8'd1);
            r[i] = k[idx];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  idx;
        r = 48'd0;
        for (int i = 0; i < 48; i++) begin
            idx  = 6'(PC2_TBL[8*(47-i) +: 8] - 8'd1);
            r[i] = cd[idx];
        end
        return r;
    endfunction

    // Bit i holds FIPS bit i+1, so a FIPS left rotation moves bits toward index 0.
    function automatic logic [27:0] rotl1(input logic [27:0] x);
        return {x[0], x[27:1]};
    endfunction

    function automatic logic [27:0] rotl2(input logic [27:0] x);
        return {x[1:0], x[27:2]};
    endfunction

    function automatic logic [27:0] rotr1(input logic [27:0] x);
        return {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr2(input logic [27:0] x);
        return {x[25:0], x[27:26]};
    endfunction

`ifdef DES_KEY_PARITY_CHK_EN
    function automatic logic key_par_err(input logic [63:0] k);
        logic e;
        e = 1'b0;
        for (int b = 0; b < 8; b++) begin
            e = e | ~(^k[8*b +: 8]);
        end
        return e;
    endfunction
`endif

    state_t      state_r, state_nxt_s;
    logic [27:0] c_r, d_r, c_nxt_s, d_nxt_s;
    logic [3:0]  count_r, count_nxt_s;
    logic        decrypt_r, decrypt_nxt_s;
    logic [55:0] cd0_s;
    logic        single_s;

    assign cd0_s    = pc1(key);
    // Rounds 1, 2, 9 and 16 use a single-bit shift in both directions.
    assign single_s = (count_r == 4'd0) || (count_r == 4'd7) || (count_r == 4'd14);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (key_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (subkey_ready && (count_r == 4'd15)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        key_ready    = 1'b0;
        busy         = 1'b0;
        subkey_valid = 1'b0;
        case (state_r)
            IDLE:    key_ready = 1'b1;
            RUN: begin
                busy         = 1'b1;
                subkey_valid = 1'b1;
            end
            default: key_ready = 1'b0;
        endcase
    end

    // C/D, round counter and direction updates for load and advance.
    always_comb begin
        c_nxt_s       = c_r;
        d_nxt_s       = d_r;
        count_nxt_s   = count_r;
        decrypt_nxt_s = decrypt_r;
        case (state_r)
            IDLE: begin
                if (key_valid) begin
                    count_nxt_s   = 4'd0;
                    decrypt_nxt_s = decrypt;
                    if (decrypt) begin
                        c_nxt_s = cd0_s[27:0];
                        d_nxt_s = cd0_s[55:28];
                    end else begin
                        c_nxt_s = rotl1(cd0_s[27:0]);
                        d_nxt_s = rotl1(cd0_s[55:28]);
                    end
                end else begin
                    count_nxt_s = count_r;
                end
            end
            RUN: begin
                if (subkey_ready && (count_r != 4'd15)) begin
                    count_nxt_s = count_r + 4'd1;
                    if (decrypt_r) begin
                        c_nxt_s = single_s ? rotr1(c_r) : rotr2(c_r);
                        d_nxt_s = single_s ? rotr1(d_r) : rotr2(d_r);
                    end else begin
                        c_nxt_s = single_s ? rotl1(c_r) : rotl2(c_r);
                        d_nxt_s = single_s ? rotl1(d_r) : rotl2(d_r);
                    end
                end else begin
                    count_nxt_s = count_r;
                end
            end
            default: count_nxt_s = count_r;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_r       <= 28'd0;
            d_r       <= 28'd0;
            count_r   <= 4'd0;
            decrypt_r <= 1'b0;
        end else begin
            c_r       <= c_nxt_s;
            d_r       <= d_nxt_s;
            count_r   <= count_nxt_s;
            decrypt_r <= decrypt_nxt_s;
        end
    end

    assign subkey      = pc2({d_r, c_r});
    assign subkey_rnd  = decrypt_r ? (4'd15 - count_r) : count_r;
    assign subkey_last = (state_r == RUN) && (count_r == 4'd15);

`ifdef DES_KEY_PARITY_CHK_EN
    logic parity_err_r;

    // Parity flag captured at key acceptance and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_r <= 1'b0;
        end else if ((state_r == IDLE) && key_valid) begin
            parity_err_r <= key_par_err(key);
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule
